// File: rtl/i2si_ctrl.sv
// I2S input control stage: frame-aligned arming of the deserializer, per-half-frame
// SCK bit-count check, and a small sample-pair FIFO with a valid/ready consumer side.
module i2si_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int BITS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rf_i2si_en,
  input  logic                     rf_i2si_clr,
  input  logic                     i2si_sck,
  input  logic                     i2si_ws,
  input  logic [DATA_W-1:0]        i2si_lft,
  input  logic [DATA_W-1:0]        i2si_rgt,
  input  logic                     i2si_xfc,
  output logic                     des_en,
  output logic [DATA_W-1:0]        fifo_lft,
  output logic [DATA_W-1:0]        fifo_rgt,
  output logic                     fifo_vld,
  input  logic                     fifo_rdy,
  output logic [$clog2(DEPTH):0]   fifo_lvl,
  output logic                     i2si_ovf,
  output logic                     i2si_ferr,
  output logic                     i2si_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [5:0]  BITS_C   = 6'(BITS);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_STOP} state_t;

  // [0],[1] are the synchronizer stages, [2] is the edge-detect history
  logic [2:0] r_sck_sy, r_ws_sy;
  logic       r_sck_rise, r_ws_rise, r_ws_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sy   <= '0;
      r_ws_sy    <= '0;
      r_sck_rise <= 1'b0;
      r_ws_rise  <= 1'b0;
      r_ws_fall  <= 1'b0;
    end else begin
      r_sck_sy   <= {r_sck_sy[1:0], i2si_sck};
      r_ws_sy    <= {r_ws_sy[1:0], i2si_ws};
      r_sck_rise <= r_sck_sy[1] & ~r_sck_sy[2];
      r_ws_rise  <= r_ws_sy[1] & ~r_ws_sy[2];
      r_ws_fall  <= ~r_ws_sy[1] & r_ws_sy[2];
    end
  end

  state_t     r_state;
  logic       r_des_en, r_busy, r_ferr;
  logic [5:0] r_cnt;
  logic       w_ws_edge, w_ferr_set;

  assign w_ws_edge  = r_ws_rise | r_ws_fall;
  // des_en is high exactly in RUN/STOP, so it doubles as the framing-check window
  assign w_ferr_set = r_des_en & w_ws_edge & (r_cnt != BITS_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_des_en <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_ferr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (rf_i2si_en) begin
          r_state <= S_ARM;
          r_busy  <= 1'b1;
        end
        S_ARM: if (!rf_i2si_en) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else if (r_ws_fall) begin
          r_state  <= S_RUN;
          r_des_en <= 1'b1;
          r_cnt    <= {5'd0, r_sck_rise};
        end
        S_RUN: if (!rf_i2si_en) r_state <= S_STOP;
        S_STOP: if (r_ws_fall) begin
          r_state  <= S_IDLE;
          r_des_en <= 1'b0;
          r_busy   <= 1'b0;
        end else if (rf_i2si_en) begin
          r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_des_en) begin
        if (w_ws_edge)                          r_cnt <= {5'd0, r_sck_rise};
        else if (r_sck_rise && r_cnt != 6'd63)  r_cnt <= r_cnt + 6'd1;
      end
      r_ferr <= w_ferr_set | (r_ferr & ~rf_i2si_clr);
    end
  end

  logic [DATA_W-1:0] r_mem_l [DEPTH];
  logic [DATA_W-1:0] r_mem_r [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_lvl;
  logic              r_ovf;
  logic              w_vld, w_full, w_pop, w_push_req, w_push, w_ovf_set;

  assign w_vld      = (r_lvl != '0);
  assign w_full     = (r_lvl == FULL_LVL);
  assign w_pop      = w_vld & fifo_rdy;
  assign w_push_req = i2si_xfc & r_des_en;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
      r_ovf <= w_ovf_set | (r_ovf & ~rf_i2si_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_l[r_wp] <= i2si_lft;
      r_mem_r[r_wp] <= i2si_rgt;
    end
  end

  assign fifo_lft  = w_vld ? r_mem_l[r_rp] : '0;
  assign fifo_rgt  = w_vld ? r_mem_r[r_rp] : '0;
  assign fifo_vld  = w_vld;
  assign fifo_lvl  = r_lvl;
  assign i2si_ovf  = r_ovf;
  assign i2si_ferr = r_ferr;
  assign des_en    = r_des_en;
  assign i2si_busy = r_busy;
endmodule

// File: doc/i2si_ctrl.md
Name: i2si_ctrl

Overview:
- Control and buffering stage placed after i2si_deserializer in the I2S input path.
- Arms the deserializer only on a frame boundary (WS falling edge = left-channel start) and stops it cleanly at a frame end.
- Checks SCK bit count per WS half-frame; buffers left/right sample pairs on each i2si_xfc into a small FIFO.
- Presents the FIFO to the consumer through a valid/ready handshake, with sticky overflow and framing-error flags for the register file.

Parameters:
- DATA_W, 16, sample width of i2si_lft/i2si_rgt.
- DEPTH, 4, FIFO depth in sample pairs; power of 2, at least 2.
- BITS, 16, expected SCK rising edges per WS half-frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rf_i2si_en  in  1  register-file enable request.
- rf_i2si_clr  in  1  single-cycle pulse; clears the sticky flags.
- i2si_sck  in  1  raw I2S bit clock (asynchronous).
- i2si_ws  in  1  raw I2S word select (asynchronous).
- i2si_lft  in  DATA_W  left sample from the deserializer.
- i2si_rgt  in  DATA_W  right sample from the deserializer.
- i2si_xfc  in  1  single-cycle pulse; sample pair complete.
- des_en  out  1  enable to the deserializer's rf_i2si_en.
- fifo_lft  out  DATA_W  head-of-FIFO left sample.
- fifo_rgt  out  DATA_W  head-of-FIFO right sample.
- fifo_vld  out  1  FIFO not empty.
- fifo_rdy  in  1  consumer accepts the head entry.
- fifo_lvl  out  clog2(DEPTH)+1  current FIFO occupancy.
- i2si_ovf  out  1  sticky overflow flag.
- i2si_ferr  out  1  sticky framing-error flag.
- i2si_busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state IDLE; des_en=0; FIFO empty (fifo_vld=0, fifo_lvl=0); fifo_lft/fifo_rgt=0; i2si_ovf=0; i2si_ferr=0; bit counter=0; sync flops=0.
- Synchronization: 2-FF synchronizers on sck and ws, plus one history flop each for edge detect. Edge pulses (sck_rise, ws_rise, ws_fall) lag the pins by 3 clk.
- FSM states and transitions:
  - IDLE: des_en=0. rf_i2si_en=1 -> ARM.
  - ARM: des_en=0. rf_i2si_en=0 -> IDLE. ws_fall -> RUN, with bit counter cleared that cycle; des_en goes high the following cycle.
  - RUN: des_en=1. rf_i2si_en=0 -> STOP.
  - STOP: des_en=1. ws_fall -> IDLE, with des_en=0 the next cycle. rf_i2si_en=1 again -> RUN (no re-arm).
- Framing check (RUN/STOP only):
  - Counter increments on each sck_rise and saturates at 63.
  - On any ws edge: if count != BITS, set i2si_ferr; the counter then restarts at 0, or at 1 if sck_rise coincides.
  - The arming ws_fall is never checked.
- FIFO push: occurs on i2si_xfc while des_en=1. It writes the {i2si_lft, i2si_rgt} values sampled in the i2si_xfc cycle. fifo_vld rises one cycle after i2si_xfc when the FIFO was empty.
- FIFO pop: occurs on fifo_vld && fifo_rdy. fifo_lft/fifo_rgt are read combinationally from the storage at the read pointer, so data is valid whenever fifo_vld=1.
- Pointers wrap modulo DEPTH. fifo_lvl updates the cycle after each push/pop; simultaneous push and pop leaves it unchanged.
- Full FIFO:
  - Push without a same-cycle pop: the pair is dropped, i2si_ovf is set, storage is unchanged.
  - Push with a same-cycle pop: both occur, no overflow.
- Empty FIFO with fifo_rdy=1: no effect.
- i2si_xfc while des_en=0: ignored.
- rf_i2si_clr: clears i2si_ovf and i2si_ferr. If a set event occurs in the same cycle, set wins.
- FIFO contents survive IDLE and are drained only by the consumer. Only rst empties the FIFO.
- rst asserted mid-frame: immediate return to the reset state; des_en drops asynchronously.

Test Plan:
- Arm alignment: sck period 625 ns, ws toggling every 16 SCK. Assert rf_i2si_en while ws=0 -> des_en stays 0 until the next ws_fall, rises 4 clk after that pin edge, i2si_ferr=0.
- Buffering: fifo_rdy=0, inject 3 xfc pulses with lft/rgt = 0x0001/0x8001, 0x0002/0x8002, 0x0003/0x8003 -> fifo_lvl=3. Then fifo_rdy=1 -> pairs pop in order, one per clk, then fifo_vld=0.
- Overflow: fifo_rdy=0, 5 xfc pulses with DEPTH=4 -> fifo_lvl=4, i2si_ovf=1, head = 1st pair. Pulse rf_i2si_clr -> i2si_ovf=0.
- Full with simultaneous push and pop: FIFO full, fifo_rdy=1 in the xfc cycle -> no ovf, fifo_lvl stays 4, new pair lands at the tail.
- Framing error: one half-frame with 15 SCK rising edges -> i2si_ferr=1 at the closing ws edge. Following 16-edge half-frames leave it set until rf_i2si_clr.
- Stop and reset: drop rf_i2si_en mid-frame -> des_en held until ws_fall, then IDLE, FIFO contents retained. Assert rst mid-RUN -> des_en=0, fifo_lvl=0, flags 0 immediately.
